// File: rtl/trng_word_packer.sv
// Packs TRNG sampler slices into OUT_W-bit words (first slice in the MSBs) and
// queues them in a small first-word-fall-through buffer with drop accounting.
module trng_word_packer #(
    parameter int IN_W  = 1,
    parameter int OUT_W = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [IN_W-1:0]            in,
    input  logic                       clear,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);
    localparam int SLICES = OUT_W / IN_W;
    localparam int SC_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [SC_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [OUT_W-1:0] mem_q [DEPTH];

    logic [OUT_W-1:0] word_next;
    logic [DEPTH-1:0] wr_en;
    logic             word_done, push, pop, drop, not_empty, is_full;

    // A single-slice word has nothing to shift in from the accumulator.
    generate
        if (SLICES > 1) begin : g_shift
            assign word_next = {acc_q[OUT_W-IN_W-1:0], in};
        end else begin : g_direct
            assign word_next = in;
        end
    endgenerate

    assign not_empty = (level_q != '0);
    assign is_full   = (level_q == LVL_W'(DEPTH));
    assign word_done = en && (cnt_q == SC_W'(SLICES - 1));
    assign pop       = not_empty && out_ready;
    // Popping on the same edge frees a slot, so a full queue can still accept.
    assign push      = word_done && (!is_full || pop);
    assign drop      = word_done && is_full && !pop;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (en) begin
            acc_d = word_next;
            cnt_d = word_done ? '0 : cnt_q + SC_W'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        // A drop outranks a coincident clear: the count restarts at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear)            drop_cnt_d = CNT_W'(1);
            else if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else if (clear) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Queue storage needs no reset: out is masked while the queue is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst && wr_en[i]) mem_q[i] <= word_next;
        end
    end

    assign out_valid = not_empty;
    assign out       = not_empty ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_trng_word_packer.sv
// Directed bench for trng_word_packer: a bit-serial byte instance with a
// two-word queue and a nibble-fed 16-bit instance.
module tb_trng_word_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial instance: IN_W=1, OUT_W=8, DEPTH=2, CNT_W=2
    logic       rst_b = 1'b0, en_b = 1'b0, clear_b = 1'b0, rdy_b = 1'b0;
    logic [0:0] in_b = '0;
    logic       valid_b, full_b, ovf_b;
    logic [7:0] out_b;
    logic [1:0] level_b;
    logic [1:0] cnt_b;

    // Nibble instance: IN_W=4, OUT_W=16, DEPTH=4, CNT_W=8
    logic        rst_n = 1'b0, en_n = 1'b0, clear_n = 1'b0, rdy_n = 1'b0;
    logic [3:0]  in_n = '0;
    logic        valid_n, full_n, ovf_n;
    logic [15:0] out_n;
    logic [2:0]  level_n;
    logic [7:0]  cnt_n;

    int checks = 0;
    int errors = 0;

    trng_word_packer #(.IN_W(1), .OUT_W(8), .DEPTH(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .in(in_b), .clear(clear_b),
        .out_ready(rdy_b), .out_valid(valid_b), .out(out_b), .level(level_b),
        .full(full_b), .overflow(ovf_b), .drop_cnt(cnt_b)
    );

    trng_word_packer #(.IN_W(4), .OUT_W(16), .DEPTH(4), .CNT_W(8)) dut_n (
        .clk(clk), .rst(rst_n), .en(en_n), .in(in_n), .clear(clear_n),
        .out_ready(rdy_n), .out_valid(valid_n), .out(out_n), .level(level_n),
        .full(full_n), .overflow(ovf_n), .drop_cnt(cnt_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift one byte in MSB first; out_ready may be raised for the final edge.
    task automatic pack_byte(input logic [7:0] w, input logic rdy_last, input logic clr_last);
        for (int i = 7; i >= 0; i--) begin
            en_b = 1'b1;
            in_b = w[i];
            if (i == 0) begin
                rdy_b   = rdy_last;
                clear_b = clr_last;
            end
            tick();
        end
        en_b = 1'b0; rdy_b = 1'b0; clear_b = 1'b0;
    endtask

    task automatic pop_b();
        rdy_b = 1'b1;
        tick();
        rdy_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b1; rst_n = 1'b1;
        tick();
        rst_b = 1'b0; rst_n = 1'b0;
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %b want 0", valid_b); end
        checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL reset_out_b got %h want 00", out_b); end
        checks++; if (level_b !== 2'd0) begin errors++; $display("FAIL reset_level_b got %0d want 0", level_b); end
        checks++; if (full_b !== 1'b0) begin errors++; $display("FAIL reset_full_b got %b want 0", full_b); end
        checks++; if ({ovf_b, cnt_b} !== 3'b000) begin errors++; $display("FAIL reset_ovf_b got %b/%0d want 0/0", ovf_b, cnt_b); end
        checks++; if ({valid_n, out_n, level_n, full_n, ovf_n, cnt_n} !== '0) begin
            errors++; $display("FAIL reset_nibble_outputs got v=%b o=%h l=%0d", valid_n, out_n, level_n); end
        $display("reset: all outputs checked");
    endtask

    task automatic test_pack();
        logic [7:0] bits;
        bits = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            en_b = 1'b1; in_b = bits[i];
            checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL pack_valid_early slice %0d got %b want 0", 7 - i, valid_b); end
            tick();
        end
        en_b = 1'b0;
        checks++; if (out_b !== 8'hB2) begin errors++; $display("FAIL pack_out got %h want b2", out_b); end
        checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL pack_valid got %b want 1", valid_b); end
        checks++; if (level_b !== 2'd1) begin errors++; $display("FAIL pack_level got %0d want 1", level_b); end
        pop_b();
        checks++; if (valid_b !== 1'b0 || out_b !== 8'h00) begin errors++; $display("FAIL pack_drain got v=%b o=%h want 0/00", valid_b, out_b); end
        $display("pack: word b2 observed as %h", 8'hB2);
    endtask

    task automatic test_gapped();
        logic [7:0] bits;
        bits = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            en_b = 1'b1; in_b = bits[i];
            checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL gap_valid_early slice %0d got %b want 0", 7 - i, valid_b); end
            tick();
            en_b = 1'b0; in_b = ~bits[i];
            if (i != 0) tick();
        end
        checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL gap_valid got %b want 1", valid_b); end
        checks++; if (out_b !== 8'hB2) begin errors++; $display("FAIL gap_out got %h want b2", out_b); end
        pop_b();
        $display("gapped: word b2 with idle cycles between slices");
    endtask

    task automatic test_overflow();
        pack_byte(8'h01, 1'b0, 1'b0);
        checks++; if (level_b !== 2'd1 || full_b !== 1'b0) begin errors++; $display("FAIL ovf_lvl1 got l=%0d f=%b want 1/0", level_b, full_b); end
        pack_byte(8'h02, 1'b0, 1'b0);
        checks++; if (full_b !== 1'b1 || level_b !== 2'd2) begin errors++; $display("FAIL ovf_full got l=%0d f=%b want 2/1", level_b, full_b); end
        checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf_b); end
        pack_byte(8'h03, 1'b0, 1'b0);
        checks++; if (ovf_b !== 1'b1 || cnt_b !== 2'd1) begin errors++; $display("FAIL ovf_drop got o=%b c=%0d want 1/1", ovf_b, cnt_b); end
        checks++; if (level_b !== 2'd2 || out_b !== 8'h01) begin errors++; $display("FAIL ovf_queue got l=%0d o=%h want 2/01", level_b, out_b); end
        pop_b();
        checks++; if (out_b !== 8'h02 || level_b !== 2'd1) begin errors++; $display("FAIL ovf_pop1 got o=%h l=%0d want 02/1", out_b, level_b); end
        pop_b();
        checks++; if (valid_b !== 1'b0 || out_b !== 8'h00 || level_b !== 2'd0) begin
            errors++; $display("FAIL ovf_pop2 got v=%b o=%h l=%0d want 0/00/0", valid_b, out_b, level_b); end
        clear_b = 1'b1; tick(); clear_b = 1'b0;
        checks++; if (ovf_b !== 1'b0 || cnt_b !== 2'd0) begin errors++; $display("FAIL ovf_clear got o=%b c=%0d want 0/0", ovf_b, cnt_b); end
        $display("overflow: third word dropped, queue drained 01,02");
    endtask

    task automatic test_push_pop_full();
        pack_byte(8'h01, 1'b0, 1'b0);
        pack_byte(8'h02, 1'b0, 1'b0);
        pack_byte(8'h03, 1'b1, 1'b0);
        checks++; if (level_b !== 2'd2 || full_b !== 1'b1) begin errors++; $display("FAIL ppf_level got l=%0d f=%b want 2/1", level_b, full_b); end
        checks++; if (ovf_b !== 1'b0 || cnt_b !== 2'd0) begin errors++; $display("FAIL ppf_ovf got o=%b c=%0d want 0/0", ovf_b, cnt_b); end
        checks++; if (out_b !== 8'h02) begin errors++; $display("FAIL ppf_head got %h want 02", out_b); end
        pop_b();
        checks++; if (out_b !== 8'h03) begin errors++; $display("FAIL ppf_next got %h want 03", out_b); end
        pop_b();
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL ppf_drain got %b want 0", valid_b); end
        $display("push_pop_full: 01 popped while 03 accepted");
    endtask

    task automatic test_back_to_back();
        pack_byte(8'h11, 1'b0, 1'b0);
        pack_byte(8'h22, 1'b1, 1'b0);
        checks++; if (out_b !== 8'h22 || level_b !== 2'd1) begin errors++; $display("FAIL b2b_head got o=%h l=%0d want 22/1", out_b, level_b); end
        pop_b();
        checks++; if (level_b !== 2'd0) begin errors++; $display("FAIL b2b_drain got %0d want 0", level_b); end
        $display("back_to_back: level-1 push+pop makes 22 the head");
    endtask

    task automatic test_clear_vs_drop();
        logic [1:0] exp_cnt;
        pack_byte(8'hA0, 1'b0, 1'b0);
        pack_byte(8'hA1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            pack_byte(8'hF0, 1'b0, 1'b0);
            exp_cnt = (k > 3) ? 2'd3 : 2'(k);
            checks++; if (cnt_b !== exp_cnt || ovf_b !== 1'b1) begin
                errors++; $display("FAIL sat_drop %0d got c=%0d o=%b want %0d/1", k, cnt_b, ovf_b, exp_cnt); end
        end
        clear_b = 1'b1; tick(); clear_b = 1'b0;
        checks++; if (ovf_b !== 1'b0 || cnt_b !== 2'd0) begin errors++; $display("FAIL clr_nodrop got o=%b c=%0d want 0/0", ovf_b, cnt_b); end
        checks++; if (level_b !== 2'd2 || out_b !== 8'hA0) begin errors++; $display("FAIL clr_queue got l=%0d o=%h want 2/a0", level_b, out_b); end
        pack_byte(8'h00, 1'b0, 1'b0);
        pack_byte(8'hF1, 1'b0, 1'b1);
        checks++; if (ovf_b !== 1'b1 || cnt_b !== 2'd1) begin errors++; $display("FAIL clr_with_drop got o=%b c=%0d want 1/1", ovf_b, cnt_b); end
        pop_b();
        pop_b();
        clear_b = 1'b1; tick(); clear_b = 1'b0;
        $display("clear_vs_drop: saturation at 3 and drop-over-clear");
    endtask

    task automatic test_nibble();
        logic [15:0] w;
        w = 16'hA5C3;
        for (int i = 3; i >= 0; i--) begin en_n = 1'b1; in_n = w[i*4 +: 4]; tick(); end
        en_n = 1'b0;
        checks++; if (out_n !== 16'hA5C3 || valid_n !== 1'b1) begin errors++; $display("FAIL nib_word got o=%h v=%b want a5c3/1", out_n, valid_n); end
        rdy_n = 1'b1; tick(); rdy_n = 1'b0;
        en_n = 1'b1; in_n = 4'hA; tick(); in_n = 4'h5; tick(); en_n = 1'b0;
        rst_n = 1'b1; tick(); rst_n = 1'b0;
        checks++; if (valid_n !== 1'b0 || level_n !== 3'd0) begin errors++; $display("FAIL nib_rst got v=%b l=%0d want 0/0", valid_n, level_n); end
        w = 16'h1234;
        for (int i = 3; i >= 0; i--) begin en_n = 1'b1; in_n = w[i*4 +: 4]; tick(); end
        en_n = 1'b0;
        checks++; if (out_n !== 16'h1234 || level_n !== 3'd1) begin errors++; $display("FAIL nib_after_rst got o=%h l=%0d want 1234/1", out_n, level_n); end
        $display("nibble: a5c3 packed, partial word discarded by reset, 1234 packed");
    endtask

    initial begin
        test_reset();
        test_pack();
        test_gapped();
        test_overflow();
        test_push_pop_full();
        test_back_to_back();
        test_clear_vs_drop();
        test_nibble();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
